// File: rtl/serial_add_sequencer_if.sv
// Command/result handshake bundle for the bit-serial adder sequencer.
// The requester drives through master; the sequencer uses slave.
interface serial_add_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             abort;
    logic             busy;
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start_valid, a, b, carry_in, abort, done_ready,
        input  start_ready, busy, done_valid, sum, carry_out, overflow
    );

    modport slave (
        input  start_valid, a, b, carry_in, abort, done_ready,
        output start_ready, busy, done_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock.
// Define SERIAL_ADD_OVF_EN to build signed-overflow capture logic.
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_add_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fa_s;
    logic             fa_c;

    assign fa_s = a_q[0] ^ b_q[0] ^ c_q;
    assign fa_c = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    c_d     = bus.carry_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // abort wins even on the final bit
                if (bus.abort) begin
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    a_d   = a_q >> 1;
                    b_d   = b_q >> 1;
                    sum_d = {fa_s, sum_q[WIDTH-1:1]};
                    c_d   = fa_c;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        cout_d  = fa_c;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.done_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.busy        = (state_q == RUN);
    assign bus.done_valid  = (state_q == DONE);
    assign bus.sum         = sum_q;
    assign bus.carry_out   = cout_q;

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q, ovf_d;
    logic accept;
    logic last_bit;

    assign accept   = (state_q == IDLE) && bus.start_valid;
    assign last_bit = (state_q == RUN) && !bus.abort
                    && (cnt_q == LAST);

    // carry into the MSB is the carry FF on the last bit
    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = 1'b0;
        end else if (last_bit) begin
            ovf_d = c_q ^ fa_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.overflow = ovf_q;
`else
    assign bus.overflow = 1'b0;
`endif
endmodule
